apb_regfile_completer: RTL
==========================

# apb_regfile_completer

APB3 completer (slave end) containing a bank of 32-bit read/write registers plus one read-only ID word. It answers transfers issued by the team's APB master and adds a programmable number of wait states per access. It also reports errors on PSLVERR. It is the standard register-hosting endpoint behind the APB bus in our designs.

## Interface
- NUM_REGS, 4, number of RW 32-bit registers; word indices 0..NUM_REGS-1
- ADDR_W, 8, PADDR width; byte address, word index = PADDR[ADDR_W-1:2]
- WAIT_STATES, 1, PREADY-low cycles inserted in each access phase (0..15)
- ID_VALUE, 32'hA9B0_0001, value returned at word index NUM_REGS (read-only)
- PCLK  input  1  bus clock, all logic on rising edge
- reset  input  1  reset, asynchronous, active-high
- PSEL  input  1  completer select
- PENABLE  input  1  access-phase indicator
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDR_W  byte address
- PWDATA  input  32  write data
- PRDATA  output  32  read data, valid only while PREADY=1 in a read access
- PREADY  output  1  transfer completes on this cycle
- PSLVERR  output  1  error response, valid only while PREADY=1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1 and PENABLE=0. Address and direction are latched here.
  - SETUP -> ACCESS when PSEL=1 and PENABLE=1.
  - ACCESS -> IDLE when PREADY=1.
  - ACCESS -> SETUP when PREADY=1 and a new PSEL=1, PENABLE=0 arrives on the same cycle. This supports back-to-back transfers.
- Wait counter: loaded with WAIT_STATES on entry to SETUP and decremented each ACCESS cycle. PREADY=1 when the counter is 0 in ACCESS.
- Write commit: happens on the edge where PSEL & PENABLE & PWRITE & PREADY. Data is taken from PWDATA on that edge. Only one register changes per transfer.
- Read: PRDATA is driven from the addressed word in the PREADY=1 cycle. PRDATA = 0 at all other times.
- Address decode:
  - Index < NUM_REGS: RW register.
  - Index == NUM_REGS: ID_VALUE. Writes to it are ignored and flagged as errors.
  - Index > NUM_REGS, or PADDR[1:0] != 0: invalid.
- Protocol violations:
  - PENABLE=1 seen in IDLE is ignored; the FSM stays in IDLE and PREADY stays 0.
  - PSEL dropping while in ACCESS aborts the transfer: return to IDLE, no write, PREADY stays 0.
- Address or PWRITE changing during ACCESS has no effect; the values latched in SETUP are used.

## Timing
- Reset values:
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - All registers = 0.
  - FSM = IDLE, wait counter = 0.
- Reset asserted mid-transfer: all outputs take their reset values asynchronously and no write commits. After reset deasserts, the FSM starts in IDLE.
- Transfer latency: 2 + WAIT_STATES cycles from the SETUP edge to the completion edge.
  - WAIT_STATES=0 gives PREADY=1 in the first ACCESS cycle.
- Combinational outputs: PREADY, PRDATA and PSLVERR are registered-state decoded, with no combinational path from PWDATA.
- Read-after-write: the register is updated on the completion edge. A read issued on the next transfer returns the new value.

## Configuration
- APB_SLVERR_EN defined:
  - PSLVERR=1 in the PREADY cycle for invalid addresses and for writes to the ID word.
  - Such writes are dropped, and such reads return PRDATA=0.
- APB_SLVERR_EN undefined:
  - PSLVERR is tied to 0.
  - Invalid reads return 0 and invalid writes are silently dropped.
  - Timing is identical in both builds.

## Test plan
- Write/read word 0: write 17 to addr 0, then read addr 0.
  - PRDATA=32'd17, PSLVERR=0.
  - Each transfer takes 3 cycles with WAIT_STATES=1.
- Write/read word 2: write 24'h415042 ("APB") to addr 8, then read addr 8.
  - PRDATA=32'h0041_5042, and word 0 still reads 17.
- ID and error check: read addr 0x10 (index 4 = NUM_REGS), then write 5 to addr 0x10 and read it back.
  - The read returns 32'hA9B0_0001.
  - The write gives PSLVERR=1 (with APB_SLVERR_EN), and the readback still returns ID_VALUE.
- Invalid address: read addr 0x14 or addr 0x01.
  - With APB_SLVERR_EN: PSLVERR=1, PRDATA=0.
  - Without it: PSLVERR=0, PRDATA=0.
- Back-to-back and wait states: with WAIT_STATES=3, run four consecutive writes with no IDLE gap.
  - Each write completes after 5 cycles with PREADY low for exactly 3 ACCESS cycles, and all four values read back correctly.
- Abort and reset:
  - Drop PSEL mid-ACCESS on a write of 32'hDEAD to addr 4: reg1 stays 0.
  - Assert reset during an ACCESS: PREADY drops immediately, all registers read 0 afterwards.

Source files
------------

// File: rtl/apb_regfile_completer.sv
// apb_regfile_completer: APB3 register-bank completer with wait states; APB_SLVERR_EN enables PSLVERR
module apb_regfile_completer #(
  parameter int          NUM_REGS    = 4,
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);
  localparam int IW = ADDR_W - 2;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic wr;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] rdata;
  logic [IW-1:0] idx;
  logic is_rw, is_id, start, commit;
  assign idx = addr[ADDR_W-1:2];
  assign is_rw = addr[1:0] == 2'b00 && idx < IW'(NUM_REGS);
  assign is_id = addr[1:0] == 2'b00 && idx == IW'(NUM_REGS);
  // PSEL gates PREADY so an aborted access never shows a completion
  assign PREADY = state == ACCESS && cnt == 4'd0 && PSEL;
  assign start = PSEL && !PENABLE && (state == IDLE || PREADY);
  assign commit = PREADY && PENABLE && wr && is_rw;
  always_comb
    state_nxt = start ? SETUP :
                state == SETUP ? (!PSEL ? IDLE : PENABLE ? ACCESS : SETUP) :
                state == ACCESS ? ((!PSEL || PREADY) ? IDLE : ACCESS) : IDLE;
  always_ff @(posedge PCLK or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt <= 4'(WAIT_STATES);
        addr <= PADDR;
        wr <= PWRITE;
      end else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  always_ff @(posedge PCLK or posedge reset)
    if (reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (commit) for (int i = 0; i < NUM_REGS; i++) if (idx == IW'(i)) regs[i] <= PWDATA;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) if (is_rw && idx == IW'(i)) rdata = regs[i];
    if (is_id) rdata = ID_VALUE;
  end
  assign PRDATA = (PREADY && !wr) ? rdata : '0;
`ifdef APB_SLVERR_EN
  logic err;
  assign err = !(is_rw || (is_id && !wr));
  assign PSLVERR = PREADY && err;
`else
  assign PSLVERR = 1'b0;
`endif
endmodule
